pbox_context_loader: RTL and testbench

PBOX_CONTEXT_LOADER -- requirements
Module: pbox_context_loader

---
 rtl/pbox_context_loader.sv | 147 ++++++++++++++
 tb/tb_pbox_context_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbox_context_loader.sv
// Context loader: assembles WORD_WIDTH stream words into CONTEXT_WIDTH entries
// and writes them to consecutive context memory addresses.
module pbox_context_loader #(
  parameter int unsigned CONTEXT_WIDTH = 80,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic                     CLK_I,
  input  logic                     RST_N_I,
  input  logic                     START_I,
  input  logic [ADDR_WIDTH-1:0]    BASE_ADDR_I,
  input  logic [ADDR_WIDTH:0]      COUNT_I,
  input  logic                     ABORT_I,
  input  logic [WORD_WIDTH-1:0]    WORD_I,
  input  logic                     WORD_VALID_I,
  output logic                     WORD_READY_O,
  output logic [ADDR_WIDTH-1:0]    WR_ADDR_O,
  output logic [CONTEXT_WIDTH-1:0] WR_DATA_O,
  output logic                     WR_EN_O,
  output logic                     BUSY_O,
  output logic                     DONE_O
);

  localparam int unsigned WPE   = (CONTEXT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned IDX_W = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int unsigned ASM_W = WPE * WORD_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ASM_W-1:0]         asm_q, asm_d, asm_next;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [CONTEXT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     word_ready, wr_en, busy, done;

  // Assembly register with the incoming word dropped into the current slot.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < WPE; k++) begin
      if (idx_q == IDX_W'(k)) asm_next[k*WORD_WIDTH +: WORD_WIDTH] = WORD_I;
    end
  end

  // Padding bits of the last word above CONTEXT_WIDTH are never written out.
  if (ASM_W > CONTEXT_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^asm_next[ASM_W-1:CONTEXT_WIDTH];
  end

  // Next-state, datapath next values and output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    word_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (START_I) begin
          addr_d  = BASE_ADDR_I;
          count_d = COUNT_I;
          idx_d   = '0;
          asm_d   = '0;
          state_d = (COUNT_I == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        word_ready = 1'b1;
        if (ABORT_I) begin
          // Abort wins over a word arriving in the same cycle.
          idx_d   = '0;
          state_d = StIdle;
        end else if (WORD_VALID_I) begin
          asm_d = asm_next;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            wr_data_d = asm_next[CONTEXT_WIDTH-1:0];
            wr_addr_d = addr_q;
            state_d   = StWrite;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWrite: begin
        if (ABORT_I) begin
          state_d = StIdle;
        end else begin
          wr_en   = 1'b1;
          addr_d  = addr_q + 1'b1;
          count_d = count_q - 1'b1;
          state_d = (count_q == CNT_W'(1)) ? StDone : StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Datapath registers; write port outputs hold between writes.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      idx_q     <= '0;
      asm_q     <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign WORD_READY_O = word_ready;
  assign WR_EN_O      = wr_en;
  assign BUSY_O       = busy;
  assign DONE_O       = done;
  assign WR_ADDR_O    = wr_addr_q;
  assign WR_DATA_O    = wr_data_q;

endmodule

// File: tb/tb_pbox_context_loader.sv
// Self-checking bench for pbox_context_loader: table-driven loads plus
// hand-written abort and reset sequences.
module tb_pbox_context_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        abort;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  wr_addr;
  logic [79:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  pbox_context_loader dut (
    .CLK_I       (clk),
    .RST_N_I     (rst_n),
    .START_I     (start),
    .BASE_ADDR_I (base_addr),
    .COUNT_I     (count),
    .ABORT_I     (abort),
    .WORD_I      (word),
    .WORD_VALID_I(word_valid),
    .WORD_READY_O(word_ready),
    .WR_ADDR_O   (wr_addr),
    .WR_DATA_O   (wr_data),
    .WR_EN_O     (wr_en),
    .BUSY_O      (busy),
    .DONE_O      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Monitor logs, append-only.
  logic [7:0]  wr_addr_log[$];
  logic [79:0] wr_data_log[$];
  int          wr_cyc_log[$];
  int          wr_lat_log[$];
  int          done_log[$];
  int          busy_cnt = 0;
  int          acc_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        wr_addr_log.push_back(wr_addr);
        wr_data_log.push_back(wr_data);
        wr_cyc_log.push_back(cyc);
        wr_lat_log.push_back(cyc - acc_cyc);
      end
      if (word_ready && word_valid) acc_cyc = cyc;
      if (done) done_log.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stream word j of a load is 0x11111111 * (j+1).
  function automatic logic [31:0] wgen(input int j);
    return 32'(32'h11111111 * (j + 1));
  endfunction

  function automatic logic [79:0] exp_entry(input int e);
    logic [95:0] t;
    t = {wgen(3*e + 2), wgen(3*e + 1), wgen(3*e)};
    return t[79:0];
  endfunction

  task automatic do_start(input logic [7:0] b, input logic [8:0] c, output int s);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    s         = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic feed_n(input int n, input int first);
    int k = 0;
    int t = 0;
    while (k < n && t < 100) begin
      word_valid = 1'b1;
      word       = wgen(first + k);
      if (word_ready) k++;
      @(posedge clk); #1;
      t++;
    end
    word_valid = 1'b0;
    check("feed_bound", k, n);
  endtask

  task automatic run_load(input logic [7:0] b, input logic [8:0] c, input bit gaps,
                          output int s);
    int total;
    int idx = 0;
    int t = 0;
    bit v, acc;
    do_start(b, c, s);
    total = int'(c) * 3;
    while (idx < total && t < 2000) begin
      v          = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      word_valid = v;
      word       = wgen(idx);
      acc        = v && word_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      t++;
    end
    word_valid = 1'b0;
    check("word_bound", idx, total);
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("busy_bound", busy, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0] base;
    logic [8:0] cnt;
    bit         gaps;
    int         n_wr;
    logic [7:0] addr0;
    logic [7:0] addr_last;
  } vec_t;

  vec_t vt[4];

  initial begin
    int s, wb, db, bb, got;

    vt[0] = '{base: 8'h10, cnt: 9'd2, gaps: 1'b0, n_wr: 2, addr0: 8'h10, addr_last: 8'h11};
    vt[1] = '{base: 8'hFF, cnt: 9'd2, gaps: 1'b0, n_wr: 2, addr0: 8'hFF, addr_last: 8'h00};
    vt[2] = '{base: 8'h33, cnt: 9'd0, gaps: 1'b0, n_wr: 0, addr0: 8'h00, addr_last: 8'h00};
    vt[3] = '{base: 8'h20, cnt: 9'd4, gaps: 1'b1, n_wr: 4, addr0: 8'h20, addr_last: 8'h23};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    abort = 1'b0; word = '0; word_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", word_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 80'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      wb = wr_addr_log.size();
      db = done_log.size();
      bb = busy_cnt;
      run_load(vt[i].base, vt[i].cnt, vt[i].gaps, s);
      got = wr_addr_log.size() - wb;
      check($sformatf("v%0d_nwr", i), got, vt[i].n_wr);
      check($sformatf("v%0d_ndone", i), done_log.size() - db, 1);
      if (got == vt[i].n_wr && got > 0) begin
        check($sformatf("v%0d_addr0", i), wr_addr_log[wb], vt[i].addr0);
        check($sformatf("v%0d_addr_last", i), wr_addr_log[wb+got-1], vt[i].addr_last);
        for (int e = 0; e < got; e++) begin
          check($sformatf("v%0d_data%0d", i, e), wr_data_log[wb+e], exp_entry(e));
          check($sformatf("v%0d_lat%0d", i, e), wr_lat_log[wb+e], 1);
        end
        if (!vt[i].gaps) begin
          check($sformatf("v%0d_first_wr_cyc", i), wr_cyc_log[wb] - s, 4);
          check($sformatf("v%0d_span", i), wr_cyc_log[wb+got-1] - wr_cyc_log[wb], 4*(got-1));
        end
        if (done_log.size() > db)
          check($sformatf("v%0d_done_cyc", i), done_log[db] - wr_cyc_log[wb+got-1], 1);
      end else if (vt[i].n_wr == 0) begin
        if (done_log.size() > db)
          check($sformatf("v%0d_done_cyc", i), done_log[db] - s, 1);
        check($sformatf("v%0d_busy_cycles", i), busy_cnt - bb, 1);
      end
    end

    // Abort after two words of the first entry, with a third word offered alongside.
    wb = wr_addr_log.size();
    db = done_log.size();
    do_start(8'h50, 9'd2, s);
    feed_n(2, 0);
    abort = 1'b1; word_valid = 1'b1; word = wgen(2);
    @(posedge clk); #1;
    abort = 1'b0; word_valid = 1'b0;
    check("abort_load_busy", busy, 1'b0);
    check("abort_load_ready", word_ready, 1'b0);
    idle_cycles(4);
    check("abort_load_nwr", wr_addr_log.size() - wb, 0);
    check("abort_load_ndone", done_log.size() - db, 0);
    // A fresh load must start from slot 0, not from the abandoned partial entry.
    run_load(8'h60, 9'd1, 1'b0, s);
    check("restart_nwr", wr_addr_log.size() - wb, 1);
    if (wr_addr_log.size() - wb == 1) begin
      check("restart_addr", wr_addr_log[wb], 8'h60);
      check("restart_data", wr_data_log[wb], exp_entry(0));
    end

    // Abort during the write cycle suppresses the strobe.
    wb = wr_addr_log.size();
    db = done_log.size();
    do_start(8'h70, 9'd1, s);
    feed_n(3, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_write_busy", busy, 1'b0);
    idle_cycles(3);
    check("abort_write_nwr", wr_addr_log.size() - wb, 0);
    check("abort_write_ndone", done_log.size() - db, 0);

    // START during a load is ignored; reset in WRITE clears everything.
    wb = wr_addr_log.size();
    db = done_log.size();
    do_start(8'h40, 9'd2, s);
    feed_n(1, 0);
    start = 1'b1; base_addr = 8'h80; count = 9'd0;
    word_valid = 1'b1; word = wgen(1);
    @(posedge clk); #1;
    start = 1'b0; word_valid = 1'b0;
    feed_n(1, 2);
    check("rstw_in_write_en", wr_en, 1'b1);
    check("rstw_in_write_addr", wr_addr, 8'h40);
    check("rstw_in_write_data", wr_data, exp_entry(0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw_wr_en", wr_en, 1'b0);
    check("rstw_ready", word_ready, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_wr_addr", wr_addr, 8'h00);
    check("rstw_wr_data", wr_data, 80'h0);
    rst_n = 1'b1;
    idle_cycles(6);
    check("rstw_nwr", wr_addr_log.size() - wb, 1);
    check("rstw_ndone", done_log.size() - db, 0);
    check("rstw_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
